// File: rtl/lock_entry_ctrl.sv
// Digit-lock entry controller: collects BCD digits, checks or stores the password,
// counts consecutive errors and runs the WAIT/EDIT/UNLOCK/ALARM state machine with tick timeouts.
module lock_entry_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned MAX_ERR      = 3,
  parameter int unsigned EDIT_TICKS   = 10,
  parameter int unsigned UNLOCK_TICKS = 20,
  parameter logic [4*DIGITS-1:0] INIT_PSWD = (4*DIGITS)'(16'h1234)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                identity,
  input  logic [3:0]          digit_in,
  input  logic                load,
  input  logic                del,
  input  logic                ok,
  input  logic                admin_clr,
  input  logic                tick,
  output logic [4*DIGITS-1:0] entry,
  output logic [3:0]          digit_cnt,
  output logic [1:0]          state,
  output logic [3:0]          err_cnt,
  output logic                result_vld,
  output logic                result_ok
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned TMAX = (EDIT_TICKS > UNLOCK_TICKS) ? EDIT_TICKS : UNLOCK_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] EDIT_LAST   = TW'(EDIT_TICKS - 1);
  localparam logic [TW-1:0] UNLOCK_LAST = TW'(UNLOCK_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [3:0]    DIGITS_L    = 4'(DIGITS);
  localparam logic [3:0]    MAX_ERR_L   = 4'(MAX_ERR);

  typedef enum logic [1:0] {
    S_WAIT   = 2'b00,
    S_EDIT   = 2'b01,
    S_UNLOCK = 2'b10,
    S_ALARM  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  pswd_q, pswd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    err_q, err_d;
  logic [3:0]    err_inc;
  logic [TW-1:0] tick_q, tick_d;
  logic          vld_q, vld_d;
  logic          rok_q, rok_d;
  logic          digit_valid;

  assign digit_valid = (digit_in < 4'd10);
  assign err_inc     = err_q + 4'd1;

  // Exactly one event is serviced per cycle: the highest-priority pulse present,
  // and a tick only when no key pulse is present at all.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    state_d = state_q;
    entry_d = entry_q;
    pswd_d  = pswd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tick_d  = tick_q;
    vld_d   = 1'b0;
    rok_d   = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        if (admin_clr) begin
          err_d = '0;
        end else if (ok) begin
          state_d = S_WAIT;
        end else if (load && digit_valid) begin
          state_d = S_EDIT;
          entry_d = W'(digit_in);
          cnt_d   = 4'd1;
          tick_d  = '0;
        end
      end

      S_EDIT: begin
        if (admin_clr) begin
          err_d = '0;
        end else if (ok) begin
          if (cnt_q == DIGITS_L) begin
            entry_d = '0;
            cnt_d   = '0;
            tick_d  = '0;
            if (!identity) begin
              pswd_d  = entry_q;
              state_d = S_WAIT;
            end else if (entry_q == pswd_q) begin
              vld_d   = 1'b1;
              rok_d   = 1'b1;
              err_d   = '0;
              state_d = S_UNLOCK;
            end else begin
              vld_d   = 1'b1;
              err_d   = err_inc;
              state_d = (err_inc == MAX_ERR_L) ? S_ALARM : S_WAIT;
            end
          end
        end else if (load) begin
          if (digit_valid && (cnt_q < DIGITS_L)) begin
            entry_d = (entry_q << 4) | W'(digit_in);
            cnt_d   = cnt_q + 4'd1;
            tick_d  = '0;
          end
        end else if (del) begin
          if (cnt_q != 4'd0) begin
            entry_d = entry_q >> 4;
            cnt_d   = cnt_q - 4'd1;
            tick_d  = '0;
          end
        end else if (tick) begin
          if (tick_q == EDIT_LAST) begin
            state_d = S_WAIT;
            entry_d = '0;
            cnt_d   = '0;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      S_UNLOCK: begin
        if (admin_clr) begin
          err_d = '0;
        end else if (ok) begin
          state_d = S_WAIT;
          tick_d  = '0;
        end else if (load || del) begin
          state_d = S_UNLOCK;
        end else if (tick) begin
          if (tick_q == UNLOCK_LAST) begin
            state_d = S_WAIT;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TICK_ONE;
          end
        end
      end

      S_ALARM: begin
        if (admin_clr) begin
          state_d = S_WAIT;
          err_d   = '0;
          tick_d  = '0;
        end
      end

      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      entry_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      // NOTE: the stored password is a plain register, so it is reset like any other state.
      pswd_q  <= INIT_PSWD;
      tick_q  <= '0;
      vld_q   <= 1'b0;
      rok_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pswd_q  <= pswd_d;
      tick_q  <= tick_d;
      vld_q   <= vld_d;
      rok_q   <= rok_d;
    end
  end

  assign entry      = entry_q;
  assign digit_cnt  = cnt_q;
  assign state      = state_q;
  assign err_cnt    = err_q;
  assign result_vld = vld_q;
  assign result_ok  = rok_q;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Testbench for lock_entry_ctrl: table-driven vectors, hand-written timeout/reset sequences,
// and randomized stimulus compared against a digit-queue reference model.
module tb_lock_entry_ctrl;

  localparam int DIGITS       = 4;
  localparam int MAX_ERR      = 3;
  localparam int EDIT_TICKS   = 10;
  localparam int UNLOCK_TICKS = 20;

  localparam int M_WAIT = 0, M_EDIT = 1, M_UNLOCK = 2, M_ALARM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        identity, load, del, ok, admin_clr, tick;
  logic [3:0]  digit_in;
  logic [15:0] entry;
  logic [3:0]  digit_cnt, err_cnt;
  logic [1:0]  state;
  logic        result_vld, result_ok;

  int checks   = 0;
  int failures = 0;

  lock_entry_ctrl #(
    .DIGITS(DIGITS), .MAX_ERR(MAX_ERR), .EDIT_TICKS(EDIT_TICKS),
    .UNLOCK_TICKS(UNLOCK_TICKS), .INIT_PSWD(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .identity(identity), .digit_in(digit_in),
    .load(load), .del(del), .ok(ok), .admin_clr(admin_clr), .tick(tick),
    .entry(entry), .digit_cnt(digit_cnt), .state(state), .err_cnt(err_cnt),
    .result_vld(result_vld), .result_ok(result_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: digits as a queue (oldest first), plain counters for errors and ticks.
  int          m_mode, m_err, m_ticks;
  int          m_digits[$];
  logic [15:0] m_pswd;
  bit          m_vld, m_rok;

  function automatic logic [15:0] pack_digits();
    logic [15:0] e = '0;
    foreach (m_digits[i]) e = (e << 4) | 16'(m_digits[i]);
    return e;
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT; m_err = 0; m_ticks = 0; m_digits.delete();
    m_pswd = 16'h1234; m_vld = 0; m_rok = 0;
  endtask

  task automatic model_step(input bit id, input int d, input bit ld, dl, okp, clr, tk);
    m_vld = 0; m_rok = 0;
    if (clr) begin
      m_err = 0;
      if (m_mode == M_ALARM) begin m_mode = M_WAIT; m_ticks = 0; end
    end else if (m_mode == M_ALARM) begin
      m_vld = 0;
    end else if (okp) begin
      if (m_mode == M_UNLOCK) begin
        m_mode = M_WAIT; m_ticks = 0;
      end else if (m_mode == M_EDIT && m_digits.size() == DIGITS) begin
        if (!id) begin
          m_pswd = pack_digits(); m_mode = M_WAIT;
        end else if (pack_digits() == m_pswd) begin
          m_vld = 1; m_rok = 1; m_err = 0; m_mode = M_UNLOCK;
        end else begin
          m_vld = 1; m_err++;
          m_mode = (m_err == MAX_ERR) ? M_ALARM : M_WAIT;
        end
        m_digits.delete(); m_ticks = 0;
      end
    end else if (ld) begin
      if (d < 10) begin
        if (m_mode == M_WAIT) begin
          m_digits.delete(); m_digits.push_back(d); m_mode = M_EDIT; m_ticks = 0;
        end else if (m_mode == M_EDIT && m_digits.size() < DIGITS) begin
          m_digits.push_back(d); m_ticks = 0;
        end
      end
    end else if (dl) begin
      if (m_mode == M_EDIT && m_digits.size() > 0) begin
        void'(m_digits.pop_back()); m_ticks = 0;
      end
    end else if (tk && (m_mode == M_EDIT || m_mode == M_UNLOCK)) begin
      m_ticks++;
      if (m_mode == M_EDIT && m_ticks == EDIT_TICKS) begin
        m_mode = M_WAIT; m_digits.delete(); m_ticks = 0;
      end else if (m_mode == M_UNLOCK && m_ticks == UNLOCK_TICKS) begin
        m_mode = M_WAIT; m_ticks = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " state"},      32'(state),      32'(m_mode));
    check({tag, " entry"},      32'(entry),      32'(pack_digits()));
    check({tag, " digit_cnt"},  32'(digit_cnt),  32'(m_digits.size()));
    check({tag, " err_cnt"},    32'(err_cnt),    32'(m_err));
    check({tag, " result_vld"}, 32'(result_vld), 32'(m_vld));
    check({tag, " result_ok"},  32'(result_ok),  32'(m_rok));
  endtask

  task automatic drive(input bit id, input int d, input bit ld, dl, okp, clr, tk);
    identity = id; digit_in = 4'(d); load = ld; del = dl; ok = okp; admin_clr = clr; tick = tk;
  endtask

  // One clock cycle: drive pulses, let the edge happen, sample 1 time unit later.
  task automatic cycle(input string tag, input bit id, input int d, input bit ld, dl, okp, clr, tk);
    drive(id, d, ld, dl, okp, clr, tk);
    @(posedge clk); #1;
    model_step(id, d, ld, dl, okp, clr, tk);
    compare_model(tag);
  endtask

  task automatic enter_code(input string tag, input bit id, input logic [15:0] code);
    for (int i = 0; i < DIGITS; i++) cycle(tag, id, int'(code[4*(DIGITS-1-i) +: 4]), 1, 0, 0, 0, 0);
    cycle(tag, id, 0, 0, 0, 1, 0, 0);
  endtask

  typedef struct {
    bit id; logic [3:0] d; bit ld, dl, okp, clr, tk;
    logic [1:0] st; logic [15:0] ent; logic [3:0] cnt, err; bit vld, rok;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit id, input logic [3:0] d, input bit ld, dl, okp, clr, tk,
                     input logic [1:0] st, input logic [15:0] ent, input logic [3:0] cnt, err,
                     input bit vld, rok);
    vecs.push_back('{id, d, ld, dl, okp, clr, tk, st, ent, cnt, err, vld, rok});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model("reset");
    rst_n = 1'b1;

    // id d ld dl ok clr tk | state entry cnt err vld rok
    add(1, 0, 0, 1, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0);  // del in WAIT ignored
    add(1, 1, 1, 0, 0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0,  1, 16'h0000, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0,  1, 16'h0000, 0, 0, 0, 0);  // del on empty EDIT
    add(1, 1, 1, 0, 0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(1, 2, 1, 0, 0, 0, 0,  1, 16'h0012, 2, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0,  1, 16'h0123, 3, 0, 0, 0);
    add(1, 5, 1, 0, 0, 0, 0,  1, 16'h1235, 4, 0, 0, 0);
    add(1, 6, 1, 0, 0, 0, 0,  1, 16'h1235, 4, 0, 0, 0);  // fifth load when full
    add(1, 0, 0, 1, 0, 0, 0,  1, 16'h0123, 3, 0, 0, 0);
    add(1,10, 1, 0, 0, 0, 0,  1, 16'h0123, 3, 0, 0, 0);  // digit 4'hA ignored
    add(1, 4, 1, 1, 0, 0, 0,  1, 16'h1234, 4, 0, 0, 0);  // load+del: load only
    add(1, 0, 0, 0, 1, 0, 0,  2, 16'h0000, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 0, 0,  2, 16'h0000, 0, 0, 0, 0);  // load in UNLOCK ignored
    add(1, 0, 0, 0, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);
    for (int r = 1; r <= 3; r++) begin
      add(1, 9, 1, 0, 0, 0, 0,  1, 16'h0009, 1, 4'(r-1), 0, 0);
      add(1, 9, 1, 0, 0, 0, 0,  1, 16'h0099, 2, 4'(r-1), 0, 0);
      add(1, 9, 1, 0, 0, 0, 0,  1, 16'h0999, 3, 4'(r-1), 0, 0);
      add(1, 9, 1, 0, 0, 0, 0,  1, 16'h9999, 4, 4'(r-1), 0, 0);
      add(1, 0, 0, 0, 1, 0, 0,  (r == 3) ? 2'd3 : 2'd0, 16'h0000, 0, 4'(r), 1, 0);
    end
    add(1, 0, 0, 0, 1, 0, 0,  3, 16'h0000, 0, 3, 0, 0);  // ok in ALARM
    add(1, 1, 1, 0, 0, 0, 0,  3, 16'h0000, 0, 3, 0, 0);  // load in ALARM
    add(1, 0, 0, 0, 0, 0, 1,  3, 16'h0000, 0, 3, 0, 0);  // tick in ALARM
    add(1, 0, 0, 0, 0, 1, 0,  0, 16'h0000, 0, 0, 0, 0);  // admin_clr exits
    add(0, 5, 1, 0, 0, 0, 0,  1, 16'h0005, 1, 0, 0, 0);
    add(0, 6, 1, 0, 0, 0, 0,  1, 16'h0056, 2, 0, 0, 0);
    add(0, 7, 1, 0, 0, 0, 0,  1, 16'h0567, 3, 0, 0, 0);
    add(0, 8, 1, 0, 0, 0, 0,  1, 16'h5678, 4, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);  // admin store, no pulse
    add(1, 1, 1, 0, 0, 0, 0,  1, 16'h0001, 1, 0, 0, 0);
    add(1, 2, 1, 0, 0, 0, 0,  1, 16'h0012, 2, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0,  1, 16'h0123, 3, 0, 0, 0);
    add(1, 4, 1, 0, 0, 0, 0,  1, 16'h1234, 4, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,  0, 16'h0000, 0, 1, 1, 0);  // old password now fails
    add(1, 5, 1, 0, 0, 0, 0,  1, 16'h0005, 1, 1, 0, 0);
    add(1, 6, 1, 0, 0, 0, 0,  1, 16'h0056, 2, 1, 0, 0);
    add(1, 7, 1, 0, 0, 0, 0,  1, 16'h0567, 3, 1, 0, 0);
    add(1, 8, 1, 0, 0, 0, 0,  1, 16'h5678, 4, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,  2, 16'h0000, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0,  0, 16'h0000, 0, 0, 0, 0);  // ok in UNLOCK relocks
    add(1, 7, 1, 0, 0, 0, 0,  1, 16'h0007, 1, 0, 0, 0);
    add(1, 3, 1, 0, 0, 1, 0,  1, 16'h0007, 1, 0, 0, 0);  // admin_clr wins, entry kept
    add(1, 0, 0, 1, 0, 0, 0,  1, 16'h0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,  1, 16'h0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].id, int'(vecs[i].d), vecs[i].ld, vecs[i].dl, vecs[i].okp, vecs[i].clr, vecs[i].tk);
      @(posedge clk); #1;
      model_step(vecs[i].id, int'(vecs[i].d), vecs[i].ld, vecs[i].dl, vecs[i].okp, vecs[i].clr, vecs[i].tk);
      check($sformatf("vec%0d state", i),      32'(state),      32'(vecs[i].st));
      check($sformatf("vec%0d entry", i),      32'(entry),      32'(vecs[i].ent));
      check($sformatf("vec%0d digit_cnt", i),  32'(digit_cnt),  32'(vecs[i].cnt));
      check($sformatf("vec%0d err_cnt", i),    32'(err_cnt),    32'(vecs[i].err));
      check($sformatf("vec%0d result_vld", i), 32'(result_vld), 32'(vecs[i].vld));
      check($sformatf("vec%0d result_ok", i),  32'(result_ok),  32'(vecs[i].rok));
    end

    // EDIT timeout: 9 ticks keep EDIT, the 10th returns to WAIT with entry cleared.
    cycle("to_clr", 1, 0, 0, 0, 0, 1, 0);
    cycle("to_ld", 1, 3, 1, 0, 0, 0, 0);
    cycle("to_ld", 1, 4, 1, 0, 0, 0, 0);
    for (int i = 0; i < EDIT_TICKS - 1; i++) cycle("to_tick", 1, 0, 0, 0, 0, 0, 1);
    check("edit before timeout state", 32'(state), 32'd1);
    cycle("to_tick", 1, 0, 0, 0, 0, 0, 1);
    check("edit timeout state", 32'(state), 32'd0);
    check("edit timeout entry", 32'(entry), 32'd0);

    // UNLOCK auto-relock after exactly UNLOCK_TICKS ticks.
    enter_code("ul", 1, m_pswd);
    check("unlock entered", 32'(state), 32'd2);
    for (int i = 0; i < UNLOCK_TICKS - 1; i++) cycle("ul_tick", 1, 0, 0, 0, 0, 0, 1);
    check("unlock before timeout", 32'(state), 32'd2);
    cycle("ul_tick", 1, 0, 0, 0, 0, 0, 1);
    check("unlock timeout state", 32'(state), 32'd0);

    // Asynchronous reset mid-EDIT restores the initial password.
    enter_code("rs_adm", 0, 16'h9012);
    cycle("rs_ld", 1, 1, 1, 0, 0, 0, 0);
    cycle("rs_ld", 1, 2, 1, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_model("async_reset");
    #1 rst_n = 1'b1;
    enter_code("rs_chk", 1, 16'h1234);
    check("init password after reset", 32'(state), 32'd2);

    // Randomized traffic with periodic correct entries so matches and relocks occur.
    for (int round = 0; round < 60; round++) begin
      for (int c = 0; c < 40; c++) begin
        cycle("rand", ($urandom % 5) != 0, int'($urandom_range(0, 11)),
              ($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 9) == 0,
              ($urandom % 40) == 0, ($urandom % 3) == 0);
      end
      if (round % 3 == 0) begin
        cycle("rand_clr", 1, 0, 0, 0, 0, 1, 0);
        if (m_mode == M_UNLOCK) cycle("rand_ok", 1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < DIGITS; k++) cycle("rand_del", 1, 0, 0, 1, 0, 0, 0);
        enter_code("rand_code", 1, m_pswd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
